spi_frame_bridge: RTL and testbench

- System-clock-side companion to the SPI serial engine. Consumes its received-word/ready outputs and supplies the word it loads for transmission.
- Brings each completed frame into the `clk` domain and queues received words in an RX FIFO for core logic.
- Holds a TX FIFO of response words and presents exactly one stable word per frame on `spi_data_out`.

---
 rtl/spi_frame_bridge.sv | 148 ++++++++++++++
 tb/tb_spi_frame_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_bridge.sv
// System-clock side of the SPI serial engine: synchronizes the frame-ready pulse,
// queues received words in an RX FIFO and supplies one stable response word per frame.
module spi_frame_bridge #(
   parameter int                     DATA_LENGTH = 64,
   parameter int                     FIFO_DEPTH  = 4,
   parameter logic [DATA_LENGTH-1:0] IDLE_WORD   = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_LENGTH-1:0]      spi_data_in,
   input  logic                        spi_data_ready,
   output logic [DATA_LENGTH-1:0]      spi_data_out,
   output logic [DATA_LENGTH-1:0]      rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   input  logic [DATA_LENGTH-1:0]      tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [$clog2(FIFO_DEPTH):0] rx_level,
   output logic [$clog2(FIFO_DEPTH):0] tx_level,
   output logic                        rx_overflow,
   input  logic                        ovf_clr,
   output logic                        tx_underflow,
   output logic [15:0]                 frame_count
);

   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               LVL_W    = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Frame-ready synchronizer and edge detector
   // ------------------------------------------------------------------
   logic       s1, s2, s3;
   logic [1:0] sync_fill;
   logic       armed;
   logic       frame_evt;

   // s2 holds its reset value, not a real sample of ready, until sync_fill[1]
   // is set; arming only then keeps a ready level held across reset silent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let s1->s2->s3 shift by one stage per clock
         // regardless of statement order; blocking here would collapse the chain.
         s1        <= spi_data_ready;
         s2        <= s1;
         s3        <= s2;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && !s2)
            armed <= 1'b1;
      end
   end

   assign frame_evt = s2 & ~s3 & armed;

   // ------------------------------------------------------------------
   // RX FIFO: frames in, core logic out (first-word fall-through)
   // ------------------------------------------------------------------
   logic [DATA_LENGTH-1:0] rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       rx_wr_ptr;
   logic [PTR_W-1:0]       rx_rd_ptr;
   logic                   rx_full;
   logic                   rx_pop;
   logic                   rx_push;

   assign rx_full  = (rx_level == FULL_LVL);
   assign rx_valid = (rx_level != '0);
   assign rx_pop   = rx_valid & rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
   assign rx_push  = frame_evt & (~rx_full | rx_pop);
   assign rx_data  = rx_mem[rx_rd_ptr];

   // NOTE: storage arrays carry no reset; the level counters alone define which
   // entries are valid, and leaving the array unreset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (rx_push)
         rx_mem[rx_wr_ptr] <= spi_data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_wr_ptr   <= '0;
         rx_rd_ptr   <= '0;
         rx_level    <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push)
            rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)
            rx_rd_ptr <= rx_rd_ptr + 1'b1;
         rx_level <= rx_level + LVL_W'(rx_push) - LVL_W'(rx_pop);
         if (frame_evt && !rx_push)
            rx_overflow <= 1'b1;
         else if (ovf_clr)
            rx_overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // TX FIFO: producer in, one word per frame out to the SPI engine
   // ------------------------------------------------------------------
   logic [DATA_LENGTH-1:0] tx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       tx_wr_ptr;
   logic [PTR_W-1:0]       tx_rd_ptr;
   logic                   tx_push;
   logic                   tx_pop;

   assign tx_ready = (tx_level != FULL_LVL);
   assign tx_push  = tx_valid & tx_ready;
   // Uses the level from the start of the cycle, so a same-cycle push into an
   // empty FIFO waits for the next frame.
   assign tx_pop   = frame_evt & (tx_level != '0);

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_wr_ptr    <= '0;
         tx_rd_ptr    <= '0;
         tx_level     <= '0;
         spi_data_out <= IDLE_WORD;
         tx_underflow <= 1'b0;
         frame_count  <= '0;
      end else begin
         if (tx_push)
            tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)
            tx_rd_ptr <= tx_rd_ptr + 1'b1;
         tx_level     <= tx_level + LVL_W'(tx_push) - LVL_W'(tx_pop);
         tx_underflow <= frame_evt & ~tx_pop;
         // spi_data_out only moves on a frame boundary so the engine always loads a stable word.
         if (frame_evt) begin
            frame_count  <= frame_count + 16'd1;
            spi_data_out <= tx_pop ? tx_mem[tx_rd_ptr] : IDLE_WORD;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_bridge.sv
// Self-checking bench for spi_frame_bridge: directed frame scenarios plus a randomized
// run, all compared each cycle against a queue-based reference model.
module tb_spi_frame_bridge;

   localparam int             DL    = 64;
   localparam int             DEPTH = 4;
   localparam logic [DL-1:0]  IDLE  = 64'hDEAD_BEEF_0BAD_F00D;

   logic          clk;
   logic          rst_n;
   logic [DL-1:0] spi_data_in;
   logic          spi_data_ready;
   logic [DL-1:0] spi_data_out;
   logic [DL-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [DL-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [2:0]    rx_level;
   logic [2:0]    tx_level;
   logic          rx_overflow;
   logic          ovf_clr;
   logic          tx_underflow;
   logic [15:0]   frame_count;

   spi_frame_bridge #(
      .DATA_LENGTH (DL),
      .FIFO_DEPTH  (DEPTH),
      .IDLE_WORD   (IDLE)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .spi_data_in    (spi_data_in),
      .spi_data_ready (spi_data_ready),
      .spi_data_out   (spi_data_out),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_level       (rx_level),
      .tx_level       (tx_level),
      .rx_overflow    (rx_overflow),
      .ovf_clr        (ovf_clr),
      .tx_underflow   (tx_underflow),
      .frame_count    (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [DL-1:0] rx_q[$];
   logic [DL-1:0] tx_q[$];
   logic [DL-1:0] m_out;
   logic          m_unf;
   logic          m_ovf;
   logic [15:0]   m_cnt;
   bit            m_armed;
   logic          prev_rdy;
   int            cyc;
   int            evt_at;

   int vectors;
   int errors;

   task automatic check(input string tag, input logic [DL-1:0] act, input logic [DL-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      check("rx_level", DL'(rx_level), DL'(rx_q.size()));
      check("rx_valid", DL'(rx_valid), DL'(rx_q.size() != 0));
      if (rx_q.size() != 0)
         check("rx_data", rx_data, rx_q[0]);
      check("tx_level", DL'(tx_level), DL'(tx_q.size()));
      check("tx_ready", DL'(tx_ready), DL'(tx_q.size() < DEPTH));
      check("spi_data_out", spi_data_out, m_out);
      check("tx_underflow", DL'(tx_underflow), DL'(m_unf));
      check("rx_overflow", DL'(rx_overflow), DL'(m_ovf));
      check("frame_count", DL'(frame_count), DL'(m_cnt));
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   // A ready rise driven in cycle c is a frame event at the edge ending cycle c+2.
   task automatic cycle(input logic rdy, input logic rrdy, input logic tval,
                        input logic [DL-1:0] tdat, input logic [DL-1:0] din, input logic clr);
      bit evt, rpop, tpush, oset;
      spi_data_ready = rdy;
      rx_ready       = rrdy;
      tx_valid       = tval;
      tx_data        = tdat;
      spi_data_in    = din;
      ovf_clr        = clr;
      if (rdy && !prev_rdy && m_armed)
         evt_at = cyc + 2;
      if (!rdy)
         m_armed = 1'b1;
      prev_rdy = rdy;
      @(posedge clk);
      evt   = (evt_at == cyc);
      rpop  = rrdy && (rx_q.size() != 0);
      tpush = tval && (tx_q.size() < DEPTH);
      oset  = 1'b0;
      m_unf = 1'b0;
      if (rpop)
         void'(rx_q.pop_front());
      if (evt) begin
         m_cnt++;
         if (tx_q.size() != 0)
            m_out = tx_q.pop_front();
         else begin
            m_out = IDLE;
            m_unf = 1'b1;
         end
         if (rx_q.size() < DEPTH)
            rx_q.push_back(din);
         else
            oset = 1'b1;
      end
      if (oset)
         m_ovf = 1'b1;
      else if (clr)
         m_ovf = 1'b0;
      if (tpush)
         tx_q.push_back(tdat);
      cyc++;
      #1 compare_all();
   endtask

   task automatic idle(input int n, input logic rrdy);
      for (int i = 0; i < n; i++)
         cycle(1'b0, rrdy, 1'b0, '0, '0, 1'b0);
   endtask

   // Six-clock frame: ready high 3 clk, low 3 clk; erx/etv apply in the event cycle only.
   task automatic frame(input logic [DL-1:0] w, input logic erx, input logic etv,
                        input logic [DL-1:0] etd);
      for (int i = 0; i < 6; i++)
         cycle(logic'(i < 3), logic'(i == 2) & erx, logic'(i == 2) & etv, etd, w, 1'b0);
   endtask

   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      spi_data_ready = rdy;
      rx_ready       = 1'b0;
      tx_valid       = 1'b0;
      tx_data        = '0;
      spi_data_in    = '0;
      ovf_clr        = 1'b0;
      repeat (2) @(posedge clk);
      rx_q.delete();
      tx_q.delete();
      m_out    = IDLE;
      m_unf    = 1'b0;
      m_ovf    = 1'b0;
      m_cnt    = '0;
      m_armed  = 1'b0;
      evt_at   = -1;
      prev_rdy = rdy;
      #1 compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DL-1:0] w;
      int p_rx;
      int p_tx;
      vectors = 0;
      errors  = 0;
      cyc     = 0;
      evt_at  = -1;
      #1;

      // Ready already high across reset release must not produce a frame.
      do_reset(1'b1);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 1'b0, 1'b0, '0, 64'h77, 1'b0);
      idle(6, 1'b0);

      // Two queued responses, two frames, then drain RX.
      do_reset(1'b0);
      idle(4, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, {8{8'hA5}}, '0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, '0, 1'b0);
      frame(64'h1, 1'b0, 1'b0, '0);
      frame(64'h2, 1'b0, 1'b0, '0);
      idle(3, 1'b1);

      // Empty TX gives IDLE + one-cycle underflow; a push coincident with the frame is too late.
      frame(64'h10, 1'b0, 1'b0, '0);
      frame(64'h11, 1'b0, 1'b1, 64'hCAFE_0000_0000_0001);
      frame(64'h12, 1'b0, 1'b0, '0);
      idle(4, 1'b1);

      // Overflow on the fifth frame, drain, then clear.
      do_reset(1'b0);
      idle(4, 1'b0);
      for (int k = 1; k <= DEPTH + 1; k++)
         frame(DL'(k), 1'b0, 1'b0, '0);
      idle(DEPTH + 1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      idle(2, 1'b0);

      // Full RX with a pop coincident with the frame: no overflow, new word at the tail.
      for (int k = 1; k <= DEPTH; k++)
         frame(DL'(k + 32'h20), 1'b0, 1'b0, '0);
      frame(64'h99, 1'b1, 1'b0, '0);
      idle(DEPTH + 1, 1'b1);

      // Reset with words queued and a frame in flight.
      cycle(1'b0, 1'b0, 1'b1, 64'h5555, '0, 1'b0);
      frame(64'h31, 1'b0, 1'b0, '0);
      frame(64'h32, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0, 64'h33, 1'b0);
      do_reset(1'b1);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b0, 1'b0, '0, 64'h33, 1'b0);
      idle(6, 1'b0);

      // Randomized traffic across pointer wrap at varying fill levels.
      do_reset(1'b0);
      idle(4, 1'b0);
      for (int f = 0; f < 300; f++) begin
         p_rx = (f / 25) % 4;
         p_tx = (f / 15) % 3;
         w    = {$urandom(), $urandom()};
         for (int i = 0; i < 6; i++)
            cycle(logic'(i < 3), logic'($urandom_range(0, 3) < p_rx),
                  logic'($urandom_range(0, 3) < p_tx), {$urandom(), $urandom()}, w,
                  logic'($urandom_range(0, 15) == 0));
      end
      check("frames_total", DL'(frame_count), 64'd300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
